bram_access_arbiter: RTL and testbench
======================================

Name: bram_access_arbiter

Overview:
- Shares one 16x8 dual-port BRAM (one write port, one read port, registered 1-cycle read) between two requester clients, A and B.
- After reset, it sweeps every address and writes a clear value. It then serves one request per cycle, using round-robin arbitration with valid/ready handshakes.
- Read responses are returned to the issuing client one cycle after the grant.
- Sits between the BRAM instance and the producer/consumer logic that needs the memory.

Parameters:
ADDR_W, 4, BRAM address width; depth = 2**ADDR_W
DATA_W, 8, BRAM data width
CLEAR_VAL, 0, value written to every location during the init sweep

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
a_req_valid  input  1  client A request valid
a_req_ready  output  1  client A request accepted this cycle
a_req_we  input  1  client A request type: 1 = write, 0 = read
a_req_addr  input  ADDR_W  client A address
a_req_wdata  input  DATA_W  client A write data
a_rsp_valid  output  1  client A read data valid
a_rsp_rdata  output  DATA_W  client A read data
b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata  same as A, for client B
mem_write_enable  output  1  to BRAM write_enable
mem_write_addr  output  ADDR_W  to BRAM write_addr
mem_write_data  output  DATA_W  to BRAM write_data
mem_read_addr  output  ADDR_W  to BRAM read_addr
mem_read_data  input  DATA_W  from BRAM read_data (registered, valid 1 cycle after mem_read_addr)
init_done  output  1  high once the clear sweep has completed

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = INIT, sweep counter = 0, rr pointer = A (B wins first contention).
  - init_done = 0, a_rsp_valid = b_rsp_valid = 0, rsp data registers = 0.
- INIT state:
  - Each cycle: mem_write_enable = 1, mem_write_addr = counter, mem_write_data = CLEAR_VAL, mem_read_addr = 0.
  - Both req_ready outputs are held 0.
  - Counter increments each cycle. After the cycle writing address 2**ADDR_W-1, state goes to RUN.
  - init_done registers to 1 on that same edge, so the sweep is exactly 2**ADDR_W cycles.
  - The counter does not wrap.
- RUN state, grant logic (combinational from current inputs):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the client that is not the rr pointer.
  - Neither valid -> no grant.
  - x_req_ready = RUN and grant_x. The handshake occurs when valid and ready are both high.
  - The rr pointer updates to the granted client on every handshake and holds otherwise.
  - At most one handshake per cycle. A request that loses stays pending; the client must hold valid and payload stable.
- Write handshake:
  - Same cycle, combinationally: mem_write_enable = 1, mem_write_addr = req_addr, mem_write_data = req_wdata.
  - Memory updates at that clock edge. No response is generated.
- Read handshake:
  - mem_read_addr = req_addr, combinationally.
  - Next cycle: x_rsp_valid = 1 (registered, one-cycle pulse) and x_rsp_rdata = mem_read_data.
  - rsp_rdata is held in the output register until the next read response to that client.
- Read latency: exactly 1 cycle from handshake to rsp_valid.
- Back-to-back: one read per cycle per client is supported. Responses are in order, with no gaps.
- Idle outputs:
  - When no handshake is a write (and in RUN), mem_write_enable = 0; mem_write_addr and mem_write_data drive 0.
  - When no handshake is a read, mem_read_addr = 0.
- Read-after-write ordering:
  - A write at cycle N is visible to a read granted at cycle N+1 or later.
  - A read and a write cannot occur in the same cycle, so no same-address hazard exists.
- Reset asserted mid-operation:
  - Any in-flight read response is dropped (rsp_valid = 0).
  - State returns to INIT and the full clear sweep reruns.
- Requests asserted during INIT are not accepted. They are served in RUN starting the cycle after init_done rises.

Test Plan:
- Reset release, no requests -> mem_write_enable high for exactly 16 cycles with addr 0..15 and data 0x00; init_done rises after cycle 16; ready low throughout; then reads of addr 0..15 all return 0x00.
- Single client: A writes 0x5A to addr 3, then reads addr 3 the next cycle -> a_rsp_valid pulses 1 cycle after the read handshake with a_rsp_rdata = 0x5A; b_rsp_valid stays 0.
- Contention: A and B both hold read valid for 4 cycles (A addr 1, B addr 2, memory pre-written 0x11 / 0x22) -> grants alternate B, A, B, A; rsp pulses alternate, with B's data = 0x22 and A's = 0x11, each 1 cycle after its grant.
- Cross-client RAW: B writes 0xC3 to addr 15 at cycle N; A reads addr 15 at N+1 -> a_rsp_rdata = 0xC3 at N+2.
- Requests during INIT: A valid (read addr 7) from reset release -> a_req_ready stays 0 until the first RUN cycle; the read is then accepted and returns 0x00.
- Mid-operation reset: assert rst_n low for 1 cycle right after an A read handshake -> no a_rsp_valid pulse, init_done drops to 0, full 16-cycle sweep repeats, and previously written 0x5A at addr 3 reads back 0x00.

Source files
------------

// File: rtl/bram_access_arbiter.sv
// rtl/bram_access_arbiter.sv - two-client round-robin arbiter in front of a 16x8 dual-port BRAM
// After reset the memory is cleared one address per cycle, then one handshake is accepted per cycle.
module bram_access_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              init_done
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;          // last granted client: 0 = A, 1 = B
  logic              init_done_q, init_done_d;
  logic              a_rsp_valid_q, a_rsp_valid_d;
  logic              b_rsp_valid_q, b_rsp_valid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic run, grant_a, grant_b;

  assign run     = (state_q == ST_RUN);
  // On contention the client that was not granted last wins.
  assign grant_a = run & a_req_valid & (~b_req_valid | rr_q);
  assign grant_b = run & b_req_valid & (~a_req_valid | ~rr_q);

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign init_done   = init_done_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  // The BRAM output is valid exactly in the response cycle, so pass it through then and hold it after.
  assign a_rsp_rdata = a_rsp_valid_q ? mem_read_data : a_rdata_q;
  assign b_rsp_rdata = b_rsp_valid_q ? mem_read_data : b_rdata_q;

  always_comb begin
    mem_write_enable = 1'b0;
    mem_write_addr   = '0;
    mem_write_data   = '0;
    mem_read_addr    = '0;
    if (!run) begin
      mem_write_enable = 1'b1;
      mem_write_addr   = cnt_q;
      mem_write_data   = CLEAR_VAL;
    end else if (grant_a) begin
      if (a_req_we) begin
        mem_write_enable = 1'b1;
        mem_write_addr   = a_req_addr;
        mem_write_data   = a_req_wdata;
      end else begin
        mem_read_addr    = a_req_addr;
      end
    end else if (grant_b) begin
      if (b_req_we) begin
        mem_write_enable = 1'b1;
        mem_write_addr   = b_req_addr;
        mem_write_data   = b_req_wdata;
      end else begin
        mem_read_addr    = b_req_addr;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_d          = rr_q;
    init_done_d   = init_done_q;
    a_rsp_valid_d = grant_a & ~a_req_we;
    b_rsp_valid_d = grant_b & ~b_req_we;
    a_rdata_d     = a_rsp_valid_q ? mem_read_data : a_rdata_q;
    b_rdata_d     = b_rsp_valid_q ? mem_read_data : b_rdata_q;
    if (!run) begin
      if (cnt_q == LAST_ADDR) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    if (grant_a) rr_d = 1'b0;
    if (grant_b) rr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      rr_q          <= 1'b0;
      init_done_q   <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_q          <= rr_d;
      init_done_q   <= init_done_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_bram_access_arbiter.sv
// tb/tb_bram_access_arbiter.sv - randomized self-checking bench for bram_access_arbiter
// A behavioural BRAM plus a transaction-level reference model predict every visible output per cycle.
module tb_bram_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_v = 1'b0, a_we = 1'b0, b_v = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wd = '0, b_wd = '0;
  logic       a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [7:0] a_rsp_rdata, b_rsp_rdata;
  logic       mem_write_enable, init_done;
  logic [3:0] mem_write_addr, mem_read_addr;
  logic [7:0] mem_write_data, mem_read_data;
  logic [7:0] bram [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_access_arbiter #(.ADDR_W(4), .DATA_W(8), .CLEAR_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_v), .a_req_ready(a_req_ready), .a_req_we(a_we),
    .a_req_addr(a_addr), .a_req_wdata(a_wd),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_v), .b_req_ready(b_req_ready), .b_req_we(b_we),
    .b_req_addr(b_addr), .b_req_wdata(b_wd),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .init_done(init_done)
  );

  always @(posedge clk) begin
    if (mem_write_enable) bram[mem_write_addr] <= mem_write_data;
    mem_read_data <= bram[mem_read_addr];
  end

  // Reference model: sweep progress, last winner, memory contents, expected responses.
  bit m_run;
  int m_swept;
  int m_last;
  int ref_mem [16];
  bit ea_v, eb_v;
  int ea_d, eb_d;
  bit m_ga, m_gb;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_swept = 0; m_last = 0;
    ea_v = 0; eb_v = 0; ea_d = 0; eb_d = 0;
    m_ga = 0; m_gb = 0;
  endtask

  task automatic check_cycle();
    bit ga, gb;
    int ewe, ewa, ewd, era;
    ga = 0; gb = 0; ewe = 0; ewa = 0; ewd = 0; era = 0;
    if (!m_run) begin
      ewe = 1; ewa = m_swept;
    end else begin
      if (a_v && b_v) begin
        ga = (m_last == 1);
        gb = !ga;
      end else begin
        ga = a_v;
        gb = b_v;
      end
      if (ga && a_we) begin ewe = 1; ewa = a_addr; ewd = a_wd; end
      if (gb && b_we) begin ewe = 1; ewa = b_addr; ewd = b_wd; end
      if (ga && !a_we) era = a_addr;
      if (gb && !b_we) era = b_addr;
    end
    check_eq("a_ready", a_req_ready, ga);
    check_eq("b_ready", b_req_ready, gb);
    check_eq("init_done", init_done, m_run);
    check_eq("we", mem_write_enable, ewe);
    check_eq("waddr", mem_write_addr, ewa);
    check_eq("wdata", mem_write_data, ewd);
    check_eq("raddr", mem_read_addr, era);
    check_eq("a_rsp_valid", a_rsp_valid, ea_v);
    check_eq("b_rsp_valid", b_rsp_valid, eb_v);
    check_eq("a_rsp_rdata", a_rsp_rdata, ea_d);
    check_eq("b_rsp_rdata", b_rsp_rdata, eb_d);

    m_ga = ga; m_gb = gb;
    ea_v = 0; eb_v = 0;
    if (!m_run) begin
      ref_mem[m_swept] = 0;
      m_swept++;
      if (m_swept == 16) m_run = 1;
    end else if (ga) begin
      m_last = 0;
      if (a_we) ref_mem[a_addr] = a_wd;
      else begin ea_v = 1; ea_d = ref_mem[a_addr]; end
    end else if (gb) begin
      m_last = 1;
      if (b_we) ref_mem[b_addr] = b_wd;
      else begin eb_v = 1; eb_d = ref_mem[b_addr]; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit v, input bit we, input int addr, input int wd);
    a_v = v; a_we = we; a_addr = addr[3:0]; a_wd = wd[7:0];
  endtask

  task automatic set_b(input bit v, input bit we, input int addr, input int wd);
    b_v = v; b_we = we; b_addr = addr[3:0]; b_wd = wd[7:0];
  endtask

  initial begin
    int n;
    model_reset();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_a_rsp_valid", a_rsp_valid, 0);
    check_eq("rst_b_rsp_valid", b_rsp_valid, 0);
    check_eq("rst_a_rdata", a_rsp_rdata, 0);

    // A holds a read of address 7 from reset release; it must wait out the sweep.
    set_a(1, 0, 7, 0);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_ga && n < 40);
    check_eq("init_wait_cycles", n, 17);
    set_a(0, 0, 0, 0);
    check_eq("init_read_rdata", a_rsp_rdata, 8'h00);

    for (int i = 0; i < 16; i++) begin
      set_a(1, 0, i, 0);
      tick();
    end
    set_a(0, 0, 0, 0);
    tick();

    set_a(1, 1, 3, 8'h5A); tick();
    set_a(1, 0, 3, 0);     tick();
    set_a(0, 0, 0, 0);
    check_eq("a_read_5a_valid", a_rsp_valid, 1);
    check_eq("a_read_5a_data", a_rsp_rdata, 8'h5A);
    tick();

    set_a(1, 1, 1, 8'h11); tick();
    set_a(1, 1, 2, 8'h22); tick();
    set_a(1, 0, 1, 0);
    set_b(1, 0, 2, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("cont_b_valid", b_rsp_valid, (k % 2 == 0));
      check_eq("cont_a_valid", a_rsp_valid, (k % 2 == 1));
      check_eq("cont_data", (k % 2 == 0) ? b_rsp_rdata : a_rsp_rdata, (k % 2 == 0) ? 8'h22 : 8'h11);
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick();

    set_b(1, 1, 15, 8'hC3); tick();
    set_b(0, 0, 0, 0);
    set_a(1, 0, 15, 0);     tick();
    set_a(0, 0, 0, 0);
    check_eq("raw_c3", a_rsp_rdata, 8'hC3);
    tick();

    for (int c = 0; c < 3000; c++) begin
      if (!a_v || m_ga) set_a(($urandom % 10) < 6, $urandom % 2, $urandom % 16, $urandom % 256);
      if (!b_v || m_gb) set_b(($urandom % 10) < 6, $urandom % 2, $urandom % 16, $urandom % 256);
      tick();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick();

    set_a(1, 1, 3, 8'h5A); tick();
    set_a(1, 0, 3, 0);     tick();
    set_a(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_a_rsp_valid", a_rsp_valid, 0);
    check_eq("midrst_init_done", init_done, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (16) tick();
    set_a(1, 0, 3, 0); tick();
    set_a(0, 0, 0, 0);
    check_eq("midrst_readback_valid", a_rsp_valid, 1);
    check_eq("midrst_readback", a_rsp_rdata, 8'h00);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
